// File: rtl/writeback_burst_engine.sv
// rtl/writeback_burst_engine.sv - AXI4 write master draining a snapshotted result vector as INCR bursts
// One burst outstanding at a time; AW, W and B are strictly sequential per burst.
module writeback_burst_engine #(
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 64,
   parameter int MAX_BURST = 16,
   parameter int ADDR_W    = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_WORDS*DATA_W-1:0] c_in_flat,
   input  logic [ADDR_W-1:0]           base_addr,
   output logic [ADDR_W-1:0]           m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [1:0]                  m_axi_awburst,
   output logic [2:0]                  m_axi_awsize,
   output logic [3:0]                  m_axi_awcache,
   output logic                        m_axi_awlock,
   output logic [2:0]                  m_axi_awprot,
   output logic [DATA_W-1:0]           m_axi_wdata,
   output logic [DATA_W/8-1:0]         m_axi_wstrb,
   output logic                        m_axi_wlast,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic                        m_axi_bready,
   input  logic [1:0]                  m_axi_bresp,
   input  logic                        m_axi_bvalid,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [1:0]                  err_resp,
   output logic [2:0]                  debug_state
);
   localparam int BYTES     = DATA_W / 8;
   localparam int SIZE_LOG2 = $clog2(BYTES);
   localparam int CNT_W     = $clog2(NUM_WORDS + 1);
   localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CMP_W     = (CNT_W > 8) ? CNT_W : 8;
   localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_buf [NUM_WORDS];
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_awaddr;
   logic [7:0]          r_awlen;
   logic [CNT_W-1:0]    r_word_idx;
   logic [CNT_W-1:0]    r_beat;
   logic                r_error;
   logic [1:0]          r_err_resp;
   logic                w_last_beat;
   logic                w_more;
   logic [IDX_W-1:0]    w_rd_idx;

   function automatic logic [7:0] f_burst_len(input logic [CNT_W-1:0] idx);
      int remain;
      remain = NUM_WORDS - int'(idx);
      if (remain > MAX_BURST) remain = MAX_BURST;
      return 8'(remain - 1);
   endfunction

   // Byte address wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] base,
                                                input logic [CNT_W-1:0]  idx);
      return base + (ADDR_W'(idx) << SIZE_LOG2);
   endfunction

   assign w_last_beat = (CMP_W'(r_beat) == CMP_W'(r_awlen));
   assign w_more      = (r_word_idx < LP_NUM);
   assign w_rd_idx    = r_word_idx[IDX_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = S_AW;
         S_AW: begin
            m_axi_awvalid = 1'b1;
            busy          = 1'b1;
            if (m_axi_awready) w_state_nxt = S_W;
         end
         S_W: begin
            m_axi_wvalid = 1'b1;
            busy         = 1'b1;
            if (m_axi_wready && w_last_beat) w_state_nxt = S_B;
         end
         S_B: begin
            m_axi_bready = 1'b1;
            busy         = 1'b1;
            if (m_axi_bvalid) w_state_nxt = w_more ? S_AW : S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base     <= '0;
         r_awaddr   <= '0;
         r_awlen    <= '0;
         r_word_idx <= '0;
         r_beat     <= '0;
         r_error    <= 1'b0;
         r_err_resp <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_base     <= base_addr;
               r_awaddr   <= base_addr;
               r_awlen    <= f_burst_len('0);
               r_word_idx <= '0;
               r_error    <= 1'b0;
               r_err_resp <= 2'b00;
            end
            S_AW: if (m_axi_awready) r_beat <= '0;
            S_W: if (m_axi_wready) begin
               r_word_idx <= r_word_idx + CNT_W'(1);
               r_beat     <= r_beat + CNT_W'(1);
            end
            S_B: if (m_axi_bvalid) begin
               // Only the first failing response of a job is kept.
               if ((m_axi_bresp != 2'b00) && !r_error) begin
                  r_error    <= 1'b1;
                  r_err_resp <= m_axi_bresp;
               end
               if (w_more) begin
                  r_awaddr <= f_addr(r_base, r_word_idx);
                  r_awlen  <= f_burst_len(r_word_idx);
               end
            end
            default: ;
         endcase
      end
   end

   // Snapshot store needs no reset: it is only read after a start has filled it.
   always_ff @(posedge clk) begin
      if ((r_state == S_IDLE) && start) begin
         for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= c_in_flat[i*DATA_W +: DATA_W];
      end
   end

   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awlen   = r_awlen;
   assign m_axi_wdata   = (r_state == S_W) ? r_buf[w_rd_idx] : '0;
   assign m_axi_wlast   = (r_state == S_W) && w_last_beat;
   assign m_axi_wstrb   = '1;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awsize  = 3'(SIZE_LOG2);
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awprot  = 3'b000;
   assign error         = r_error;
   assign err_resp      = r_err_resp;
   assign debug_state   = r_state;

endmodule

// File: tb/tb_writeback_burst_engine.sv
// tb/tb_writeback_burst_engine.sv - directed bench for writeback_burst_engine
// Slave model answers B one cycle after bready rises; a second instance covers a short tail burst.
module tb_writeback_burst_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start;
   logic [64*32-1:0] c_in_flat;
   logic [11:0] base_addr, m_awaddr;
   logic [7:0]  m_awlen;
   logic m_awvalid, m_awready, m_awlock, m_wlast, m_wvalid, m_wready;
   logic m_bready, m_bvalid, busy, done, error;
   logic [1:0]  m_awburst, m_bresp, err_resp;
   logic [2:0]  m_awsize, m_awprot, debug_state;
   logic [3:0]  m_awcache, m_wstrb;
   logic [31:0] m_wdata;

   logic t_start;
   logic [20*32-1:0] t_c_in_flat;
   logic [11:0] t_base, t_awaddr;
   logic [7:0]  t_awlen;
   logic t_awvalid, t_awlock, t_wlast, t_wvalid, t_bready, t_busy, t_done, t_error;
   logic [1:0]  t_awburst, t_err_resp;
   logic [2:0]  t_awsize, t_awprot, t_dbg;
   logic [3:0]  t_awcache, t_wstrb;
   logic [31:0] t_wdata;

   writeback_burst_engine #(.DATA_W(32), .NUM_WORDS(64), .MAX_BURST(16), .ADDR_W(12)) dut (
      .clk(clk), .rst(rst), .start(start), .c_in_flat(c_in_flat), .base_addr(base_addr),
      .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
      .m_axi_awburst(m_awburst), .m_axi_awsize(m_awsize), .m_axi_awcache(m_awcache), .m_axi_awlock(m_awlock),
      .m_axi_awprot(m_awprot), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
      .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bready(m_bready), .m_axi_bresp(m_bresp),
      .m_axi_bvalid(m_bvalid), .busy(busy), .done(done), .error(error), .err_resp(err_resp),
      .debug_state(debug_state));

   writeback_burst_engine #(.DATA_W(32), .NUM_WORDS(20), .MAX_BURST(16), .ADDR_W(12)) dut_tail (
      .clk(clk), .rst(rst), .start(t_start), .c_in_flat(t_c_in_flat), .base_addr(t_base),
      .m_axi_awaddr(t_awaddr), .m_axi_awlen(t_awlen), .m_axi_awvalid(t_awvalid), .m_axi_awready(1'b1),
      .m_axi_awburst(t_awburst), .m_axi_awsize(t_awsize), .m_axi_awcache(t_awcache), .m_axi_awlock(t_awlock),
      .m_axi_awprot(t_awprot), .m_axi_wdata(t_wdata), .m_axi_wstrb(t_wstrb), .m_axi_wlast(t_wlast),
      .m_axi_wvalid(t_wvalid), .m_axi_wready(1'b1), .m_axi_bready(t_bready), .m_axi_bresp(2'b00),
      .m_axi_bvalid(t_bready), .busy(t_busy), .done(t_done), .error(t_error), .err_resp(t_err_resp),
      .debug_state(t_dbg));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   int aw_cnt, beat_cnt, bib, wlast_cnt, b_cnt, done_cnt, job_cyc, done_cyc, mon_len, cur_len;
   int aw_wait, w_wait, b_wait;
   bit stall, job_on, aw_pend, w_pend, b_armed, last_w_hs, aw_hs;
   logic [11:0] h_awaddr, exp_base;
   logic [7:0]  h_awlen;
   logic [31:0] h_wdata;
   logic        h_wlast, exp_err;
   logic [1:0]  exp_eresp;
   logic [1:0]  resp_tbl [4];
   logic [31:0] exp_data [64];

   int t_aw_cnt, t_beats, t_wlast_cnt, t_done_cnt;
   logic [11:0] t_addrs [2];
   logic [7:0]  t_lens [2];

   // Slave and monitor: look at the DUT on the falling edge, set readies for the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
         aw_pend = 0; w_pend = 0; b_armed = 0; last_w_hs = 0; aw_hs = 0; job_on = 0;
      end else begin
         if (job_on) begin
            job_cyc++;
            if (done) begin
               done_cnt++; done_cyc = job_cyc; job_on = 0;
               check("busy_at_done", busy, 0);
            end else check("busy_hold", busy, 1);
         end else begin
            if (done) done_cnt++;
            if (start) begin job_on = 1; job_cyc = 1; end
         end
         if (aw_hs) begin check("aw_to_w", m_wvalid, 1); aw_hs = 0; end
         if (last_w_hs) begin
            check("turn_wvalid", m_wvalid, 0);
            check("turn_wlast", m_wlast, 0);
            check("turn_bready", m_bready, 1);
            last_w_hs = 0;
         end
         if (m_bvalid) begin
            check("b_to_next", m_awvalid | done, 1);
            check("error", error, exp_err);
            check("err_resp", err_resp, exp_eresp);
            m_bvalid = 1'b0; b_armed = 0;
         end
         if (aw_pend) begin
            check("aw_hold_valid", m_awvalid, 1);
            check("aw_hold_addr", m_awaddr, h_awaddr);
            check("aw_hold_len", m_awlen, h_awlen);
         end
         m_awready = 1'b0;
         if (m_awvalid) begin
            if (!aw_pend) aw_wait = stall ? $urandom_range(0, 5) : 0;
            if (aw_wait == 0) begin
               m_awready = 1'b1; aw_pend = 0; aw_hs = 1;
               mon_len = 64 - aw_cnt * 16;
               if (mon_len > 16) mon_len = 16;
               check("awaddr", m_awaddr, 12'(exp_base + aw_cnt * 64));
               check("awlen", m_awlen, mon_len - 1);
               cur_len = mon_len - 1; bib = 0; aw_cnt++;
            end else begin
               aw_wait--; aw_pend = 1; h_awaddr = m_awaddr; h_awlen = m_awlen;
            end
         end else aw_pend = 0;
         if (w_pend) begin
            check("w_hold_valid", m_wvalid, 1);
            check("w_hold_data", m_wdata, h_wdata);
            check("w_hold_last", m_wlast, h_wlast);
         end
         m_wready = 1'b0;
         if (m_wvalid) begin
            if (!w_pend) w_wait = stall ? $urandom_range(0, 5) : 0;
            if (w_wait == 0) begin
               m_wready = 1'b1; w_pend = 0;
               check("wdata", m_wdata, (beat_cnt < 64) ? exp_data[beat_cnt] : 32'hDEADDEAD);
               check("wlast", m_wlast, bib == cur_len);
               beat_cnt++; bib++;
               if (m_wlast) begin wlast_cnt++; last_w_hs = 1; end
            end else begin
               w_wait--; w_pend = 1; h_wdata = m_wdata; h_wlast = m_wlast;
            end
         end else w_pend = 0;
         if (m_bready && !m_bvalid) begin
            if (!b_armed) begin b_armed = 1; b_wait = stall ? 1 + $urandom_range(0, 5) : 1; end
            if (b_wait == 0) begin
               m_bvalid = 1'b1;
               m_bresp  = (b_cnt < 4) ? resp_tbl[b_cnt] : 2'b00;
               if (m_bresp != 2'b00 && !exp_err) begin exp_err = 1'b1; exp_eresp = m_bresp; end
               b_cnt++;
            end else b_wait--;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (t_awvalid) begin
            if (t_aw_cnt < 2) begin t_addrs[t_aw_cnt] = t_awaddr; t_lens[t_aw_cnt] = t_awlen; end
            t_aw_cnt++;
         end
         if (t_wvalid) begin
            check("t_wdata", t_wdata, 32'hB000 + t_beats);
            t_beats++;
            if (t_wlast) t_wlast_cnt++;
         end
         if (t_done) t_done_cnt++;
      end
   end

   task automatic start_job(input logic [11:0] base, input logic [31:0] seed);
      @(posedge clk); #1;
      exp_base = base; base_addr = base;
      for (int i = 0; i < 64; i++) begin
         exp_data[i] = seed + i;
         c_in_flat[i*32 +: 32] = seed + i;
      end
      aw_cnt = 0; beat_cnt = 0; wlast_cnt = 0; b_cnt = 0; done_cnt = 0; done_cyc = 0;
      exp_err = 1'b0; exp_eresp = 2'b00;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_busy", busy, 1);
      check("start_awvalid", m_awvalid, 1);
      check("start_err_clr", error, 0);
      check("start_eresp_clr", err_resp, 0);
   endtask

   task automatic finish_job(input bit chk_len);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin @(posedge clk); n++; end
      check("job_timeout", n < 3000, 1);
      repeat (4) @(posedge clk);
      #1;
      check("aw_bursts", aw_cnt, 4);
      check("beats", beat_cnt, 64);
      check("wlast_pulses", wlast_cnt, 4);
      check("b_resps", b_cnt, 4);
      check("done_pulses", done_cnt, 1);
      check("idle_busy", busy, 0);
      if (chk_len) check("done_cycle", done_cyc, 78);
   endtask

   initial begin
      int n;
      start = 1'b0; t_start = 1'b0; stall = 0; base_addr = '0; t_base = '0; c_in_flat = '0;
      for (int i = 0; i < 4; i++) resp_tbl[i] = 2'b00;
      for (int i = 0; i < 20; i++) t_c_in_flat[i*32 +: 32] = 32'hB000 + i;
      aw_cnt = 0; beat_cnt = 0; done_cnt = 0; exp_base = '0; exp_err = 0; exp_eresp = 0;
      t_aw_cnt = 0; t_beats = 0; t_wlast_cnt = 0; t_done_cnt = 0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_state", debug_state, 0);
      check("rst_awvalid", m_awvalid, 0);
      check("rst_wvalid", m_wvalid, 0);
      check("rst_bready", m_bready, 0);
      check("rst_busy_done_err", {busy, done, error, m_wlast}, 0);
      check("rst_awaddr_len", {m_awaddr, m_awlen}, 0);
      check("rst_wdata", m_wdata, 0);
      check("rst_err_resp", err_resp, 0);
      check("const_aw", {m_awburst, m_awsize, m_awcache, m_awlock, m_awprot}, {2'b01, 3'd2, 4'b0011, 1'b0, 3'b000});
      check("const_wstrb", m_wstrb, 4'hF);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      start_job(12'h100, 32'hA000);
      finish_job(1);

      @(posedge clk); #1 t_start = 1'b1;
      @(posedge clk); #1 t_start = 1'b0;
      n = 0;
      while (t_done_cnt == 0 && n < 500) begin @(posedge clk); n++; end
      check("t_timeout", n < 500, 1);
      repeat (2) @(posedge clk);
      check("t_bursts", t_aw_cnt, 2);
      check("t_len0", t_lens[0], 15);
      check("t_len1", t_lens[1], 3);
      check("t_addr0", t_addrs[0], 12'h000);
      check("t_addr1", t_addrs[1], 12'h040);
      check("t_beats", t_beats, 20);
      check("t_wlast", t_wlast_cnt, 2);
      check("t_done", t_done_cnt, 1);

      stall = 1;
      start_job(12'h100, 32'hA000);
      finish_job(0);
      stall = 0;

      resp_tbl[1] = 2'b10; resp_tbl[3] = 2'b11;
      start_job(12'h100, 32'h5000);
      finish_job(1);
      check("err_final", error, 1);
      check("err_resp_final", err_resp, 2'b10);
      resp_tbl[1] = 2'b00; resp_tbl[3] = 2'b00;

      start_job(12'h200, 32'hC000);
      n = 0;
      while (beat_cnt < 3 && n < 200) begin @(posedge clk); n++; end
      check("snap_timeout", n < 200, 1);
      #1;
      for (int i = 0; i < 64; i++) c_in_flat[i*32 +: 32] = 32'hFFFF0000 + i;
      base_addr = 12'hABC; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      finish_job(1);

      resp_tbl[0] = 2'b10;
      start_job(12'h300, 32'hD000);
      n = 0;
      while (!(aw_cnt == 3 && bib == 5) && n < 500) begin @(posedge clk); #1; n++; end
      check("rst_wait_timeout", n < 500, 1);
      check("pre_rst_error", error, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valids", {m_awvalid, m_wvalid, m_wlast, m_bready}, 0);
      check("mid_rst_flags", {busy, done, error}, 0);
      check("mid_rst_state", debug_state, 0);
      check("mid_rst_data", {m_awaddr, m_awlen, m_wdata, err_resp}, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      resp_tbl[0] = 2'b00;
      start_job(12'h100, 32'hE000);
      finish_job(1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/writeback_burst_engine.md
# writeback_burst_engine

Parametrised AXI4 write master that drains the accelerator's flattened result vector (for example, systolic-array Cout or LSTM hidden/cell state) into memory. It snapshots the vector on `start`, then writes it as one or more INCR bursts, each no longer than `MAX_BURST` beats, with the last burst shortened as needed. Each burst's write response is checked, and any error is reported as a sticky flag. It sits between the compute core and the AXI interconnect and is started by the APB control block.

## Interface
Parameters:
- `DATA_W` (32): beat width in bits; must be 32 or 64.
- `NUM_WORDS` (64): number of beats per job; must be 1..256.
- `MAX_BURST` (16): maximum beats per burst; must be 1..256.
- `ADDR_W` (12): AXI address width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: job request; sampled only in IDLE.
- `c_in_flat`, in, `NUM_WORDS*DATA_W`: result vector; word i is `[i*DATA_W +: DATA_W]`.
- `base_addr`, in, `ADDR_W`: byte address of word 0; aligned to `DATA_W/8`.
- `m_axi_awaddr`/`awlen`/`awvalid`, out, `ADDR_W`/8/1, with `m_axi_awready` in, 1: AW channel.
- `m_axi_awburst`/`awsize`/`awcache`/`awlock`/`awprot`, out, 2/3/4/1/3: constants 01, log2(`DATA_W`/8), 0011, 0, 000.
- `m_axi_wdata`/`wstrb`/`wlast`/`wvalid`, out, `DATA_W`/`DATA_W/8`/1/1, with `m_axi_wready` in, 1: W channel; `wstrb` is all ones.
- `m_axi_bready`, out, 1, with `m_axi_bresp` in, 2 and `m_axi_bvalid` in, 1: B channel.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse at job end.
- `error`, out, 1: sticky; set if any `bresp` is nonzero; cleared when the next `start` is accepted.
- `err_resp`, out, 2: the first nonzero `bresp` of the job.
- `debug_state`, out, 3: current FSM state.

## Operation
FSM states:
- **IDLE (0):**
  - On `start`, snapshot `c_in_flat` into an internal buffer and latch `base_addr`.
  - Set `word_idx` to 0 and clear `error` and `err_resp`.
  - Go to AW.
- **AW (1):**
  - Drive `awvalid=1`, `awaddr = base + word_idx*(DATA_W/8)` truncated to `ADDR_W`, and `awlen = min(MAX_BURST, NUM_WORDS-word_idx) - 1`.
  - Hold all of these stable until `awready`, then go to W with the beat counter set to 0.
- **W (2):**
  - `wvalid=1`, `wdata = buffer[word_idx]`.
  - On each `wready`, increment `word_idx` and the beat counter.
  - `wlast=1` only on the beat where the counter equals `awlen`.
  - The handshake of that beat moves to B.
- **B (3):**
  - `bready=1`.
  - On `bvalid`, if `bresp` is nonzero and `error` is 0, set `error` and capture `err_resp`.
  - Then go to AW if `word_idx < NUM_WORDS`, otherwise DONE.
- **DONE (4):** `done=1` for this one cycle, then IDLE unconditionally.

Rules:
- Exactly one burst is outstanding at a time. AW, W and B are strictly sequential per burst.
- An error does not abort the job; the remaining bursts are still written.
- `start` outside IDLE is ignored. Changes on `c_in_flat` or `base_addr` after acceptance have no effect on the current job.
- Counters are sized `$clog2(NUM_WORDS+1)` bits.
- Address wrap past `2^ADDR_W` is modular; 4 KB-crossing avoidance is the caller's responsibility.

## Timing
- **Reset (asynchronous, immediate):**
  - State goes to IDLE.
  - `awvalid`, `wvalid`, `wlast`, `bready`, `busy`, `done` and `error` are 0; `awaddr`, `awlen`, `wdata` and `err_resp` are 0.
  - Constant outputs keep their fixed values.
  - Reset mid-burst simply drops the transaction; no completion is attempted.
- **Start latency:** `start` high at clock edge t in IDLE gives `awvalid=1` and `busy=1` from t+1.
- **Beat and burst throughput:**
  - AW handshake at edge t gives `wvalid=1` at t+1.
  - With `wready` held high, one beat is transferred per cycle and `wvalid` never drops mid-burst.
- **Burst turnaround:**
  - The last W handshake at t gives `wvalid=0`, `wlast=0` and `bready=1` at t+1.
  - B handshake at t gives the next `awvalid` or `done` at t+1.
  - If `bvalid` is already high when `bready` rises, the handshake completes in that same cycle.
- **Minimum job length:** with all readies tied high, the job takes `NUM_WORDS + 3*ceil(NUM_WORDS/MAX_BURST) + 2` cycles from `start` to `done`.
- **Job completion:** `busy` falls in the same cycle `done` rises. A new `start` is accepted no earlier than the cycle after `done`.

## Test plan
- **Multi-burst job:** `NUM_WORDS=64`, `MAX_BURST=16`, `base=0x100`, readies tied high, word i = `0xA000+i`.
  - Expect 4 bursts: `awaddr` 0x100, 0x140, 0x180, 0x1C0, all with `awlen=15`.
  - `wdata` sequence is 0xA000..0xA03F, with `wlast` on beats 15, 31, 47 and 63.
  - One `done` pulse at cycle 78.
- **Short tail burst:** `NUM_WORDS=20`, `MAX_BURST=16`, `base=0x000`.
  - Expect `awlen` 15 then 3, with the second address 0x040.
  - 20 beats in total and exactly two `wlast` pulses.
- **Backpressure:** random `awready`/`wready`/`bvalid` stalls of 0-5 cycles.
  - `awaddr`, `awlen`, `wdata` and `wlast` stay stable while their valid is high and ready is low.
  - No beat is lost or duplicated; the data sequence matches the first scenario.
- **Error response:** `bresp=2'b10` on burst 1 and `2'b11` on burst 3.
  - `error` goes to 1 after burst 1, and `err_resp` stays 2'b10.
  - All 4 bursts still issue and `done` still pulses.
  - The next accepted `start` clears `error` to 0.
- **Snapshot and ignored start:** alter `c_in_flat` and pulse `start` during burst 0.
  - Written data is the vector sampled at acceptance.
  - No second job runs and `busy` stays continuous.
- **Reset mid-job:** assert `rst` during burst 2, beat 5.
  - All valids, `bready`, `busy`, `done` and `error` read 0 before the next edge.
  - A new job after reset writes from `base` cleanly.
